// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver and its baud-rate generator.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS_DEF = 8;
  localparam int NUM_TICKS_DEF = 16;
  localparam int SB_TICKS_DEF  = 16;
  localparam int CLK_RATE_DEF  = 50_000_000;
  localparam int BAUD_RATE_DEF = 115_200;

  // Tick counter width: must hold max(num_ticks, sb_ticks)-1.
  function automatic int cnt_width(input int num_ticks, input int sb_ticks);
    int m;
    m = (num_ticks > sb_ticks) ? num_ticks : sb_ticks;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  // Divider the baud-rate generator uses to produce the oversampling tick.
  function automatic int tick_div(input int clk_rate, input int baud_rate,
                                  input int num_ticks);
    return clk_rate / (baud_rate * num_ticks);
  endfunction

  localparam int TICK_DIV_DEF = tick_div(CLK_RATE_DEF, BAUD_RATE_DEF, NUM_TICKS_DEF);

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversampling tick and serial line in, received word out.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 TICK;
  logic                 RX;
  logic [DATA_BITS-1:0] DOUT;
  logic                 RX_DONE;
  logic                 FRAME_ERR;

  // Upstream side: baud generator / board pin plus the byte consumer.
  modport master (
    output TICK,
    output RX,
    input  DOUT,
    input  RX_DONE,
    input  FRAME_ERR
  );

  // The receiver itself.
  modport slave (
    input  TICK,
    input  RX,
    output DOUT,
    output RX_DONE,
    output FRAME_ERR
  );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset level.
module uart_rx_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Two back-to-back flops; both come out of reset at the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, mid-bit sampling, stop-bit check.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NUM_TICKS = NUM_TICKS_DEF,
  parameter int SB_TICKS  = SB_TICKS_DEF
) (
  input logic      CLK,
  input logic      RESET_N,
  uart_rx_if.slave bus
);
  localparam int CNT_W = cnt_width(NUM_TICKS, SB_TICKS);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] START_MID = CNT_W'(NUM_TICKS / 2 - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(NUM_TICKS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 rx_s;
  logic                 rx_prev;

  uart_rx_sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RESET_N),
    .d    (bus.RX),
    .q    (rx_s)
  );

  // One-cycle delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rx_prev <= 1'b1;
    else          rx_prev <= rx_s;
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; counters only move on TICK except the start-edge clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Edge only: a line stuck low cannot restart a frame.
        if (!rx_s && rx_prev) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (bus.TICK) begin
          if (cnt_q == START_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.TICK) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) state_d = STOP;
            else                   bit_d   = bit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.TICK) begin
          if (cnt_q == STOP_LAST) begin
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.DOUT      = dout_q;
  assign bus.RX_DONE   = done_q;
  assign bus.FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver with one stop bit, one with two stop bits.
module tb_uart_rx;
  localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] tdiv = 2'd0;
  logic       tick;
  logic       rx_line = 1'b1;
  logic       sel32 = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int done16 = 0;
  int done32 = 0;

  logic [8:0] exp16[$];
  logic [8:0] exp32[$];
  logic [8:0] last16 = '0;
  logic [8:0] last32 = '0;
  logic [8:0] e;

  uart_rx_if #(.DATA_BITS(8)) if16 ();
  uart_rx_if #(.DATA_BITS(8)) if32 ();

  uart_rx #(.DATA_BITS(8), .NUM_TICKS(16), .SB_TICKS(16)) dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(if16)
  );
  uart_rx #(.DATA_BITS(8), .NUM_TICKS(16), .SB_TICKS(32)) dut32 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(if32)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) tdiv <= tdiv + 2'd1;
  assign tick = (tdiv == 2'd3);

  assign if16.TICK = tick;
  assign if32.TICK = tick;
  assign if16.RX   = sel32 ? 1'b1 : rx_line;
  assign if32.RX   = sel32 ? rx_line : 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each pulse consumes one expected frame, outputs hold otherwise.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      last16 = '0;
      last32 = '0;
      chk("rst_done16", {31'd0, if16.RX_DONE}, 32'd0);
      chk("rst_dout16", {24'd0, if16.DOUT}, 32'd0);
      chk("rst_ferr16", {31'd0, if16.FRAME_ERR}, 32'd0);
      chk("rst_done32", {31'd0, if32.RX_DONE}, 32'd0);
      chk("rst_dout32", {24'd0, if32.DOUT}, 32'd0);
      chk("rst_ferr32", {31'd0, if32.FRAME_ERR}, 32'd0);
    end else begin
      if (if16.RX_DONE) begin
        done16++;
        if (exp16.size() == 0) chk("spurious_done16", {31'd0, if16.RX_DONE}, 32'd0);
        else begin
          e = exp16.pop_front();
          chk("dout16", {24'd0, if16.DOUT}, {24'd0, e[7:0]});
          chk("ferr16", {31'd0, if16.FRAME_ERR}, {31'd0, e[8]});
          last16 = e;
        end
      end else begin
        chk("hold_dout16", {24'd0, if16.DOUT}, {24'd0, last16[7:0]});
        chk("hold_ferr16", {31'd0, if16.FRAME_ERR}, {31'd0, last16[8]});
      end
      if (if32.RX_DONE) begin
        done32++;
        if (exp32.size() == 0) chk("spurious_done32", {31'd0, if32.RX_DONE}, 32'd0);
        else begin
          e = exp32.pop_front();
          chk("dout32", {24'd0, if32.DOUT}, {24'd0, e[7:0]});
          chk("ferr32", {31'd0, if32.FRAME_ERR}, {31'd0, e[8]});
          last32 = e;
        end
      end else begin
        chk("hold_dout32", {24'd0, if32.DOUT}, {24'd0, last32[7:0]});
        chk("hold_ferr32", {31'd0, if32.FRAME_ERR}, {31'd0, last32[8]});
      end
    end
  end

  task automatic hold(input logic lv, input int nclk);
    rx_line = lv;
    repeat (nclk) @(negedge CLK);
  endtask

  // Stop is sampled mid-first stop period with one stop bit, mid-second with two.
  task automatic send_frame(input logic [7:0] d, input logic stop_lv,
                            input logic next_lv, input bit expect_it);
    if (expect_it) begin
      if (sel32) exp32.push_back({~next_lv, d});
      else       exp16.push_back({~stop_lv, d});
    end
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    hold(stop_lv, BIT_CLK);
  endtask

  task automatic scen_end(input string name, input int exp_done16, input int exp_done32,
                          input logic [7:0] exp_dout, input logic exp_ferr);
    chk({name, "_pending16"}, exp16.size(), 32'd0);
    chk({name, "_pending32"}, exp32.size(), 32'd0);
    chk({name, "_count16"}, done16, exp_done16);
    chk({name, "_count32"}, done32, exp_done32);
    chk({name, "_state16"}, {30'd0, dut16.state_q}, 32'd0);
    chk({name, "_state32"}, {30'd0, dut32.state_q}, 32'd0);
    if (sel32) begin
      chk({name, "_dout"}, {24'd0, if32.DOUT}, {24'd0, exp_dout});
      chk({name, "_ferr"}, {31'd0, if32.FRAME_ERR}, {31'd0, exp_ferr});
    end else begin
      chk({name, "_dout"}, {24'd0, if16.DOUT}, {24'd0, exp_dout});
      chk({name, "_ferr"}, {31'd0, if16.FRAME_ERR}, {31'd0, exp_ferr});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge CLK);
    RESET_N = 1'b1;
    hold(1'b1, 100);

    // 0xA5, clean frame
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 100);
    scen_end("a5", 1, 0, 8'hA5, 1'b0);

    // 0x3C, stop bit low, then line released; no second frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    hold(1'b0, 40);
    hold(1'b1, 3 * BIT_CLK);
    scen_end("3c_ferr", 2, 0, 8'h3C, 1'b1);

    // glitch of 4 ticks, then a valid 0x5A
    hold(1'b0, 16);
    hold(1'b1, 2 * BIT_CLK);
    chk("glitch_count16", done16, 32'd2);
    chk("glitch_state16", {30'd0, dut16.state_q}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 100);
    scen_end("5a", 3, 0, 8'h5A, 1'b0);

    // back-to-back 0x00 then 0xFF, no gap
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    chk("b2b_first_dout", {24'd0, if16.DOUT}, 32'h00);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 100);
    scen_end("b2b", 5, 0, 8'hFF, 1'b0);

    // reset in the middle of bit 4 of 0x81
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    for (int i = 1; i < 4; i++) hold(1'b0, BIT_CLK);
    hold(1'b0, BIT_CLK / 2);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, if16.DOUT}, 32'd0);
    chk("midrst_done", {31'd0, if16.RX_DONE}, 32'd0);
    chk("midrst_ferr", {31'd0, if16.FRAME_ERR}, 32'd0);
    chk("midrst_state", {30'd0, dut16.state_q}, 32'd0);
    rx_line = 1'b1;
    repeat (10) @(negedge CLK);
    RESET_N = 1'b1;
    hold(1'b1, 100);
    chk("postrst_count16", done16, 32'd5);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 100);
    scen_end("81", 6, 0, 8'h81, 1'b0);

    // two stop bits: clean 0x7E, then 0x7E with next start in 2nd stop slot
    sel32 = 1'b1;
    hold(1'b1, 100);
    send_frame(8'h7E, 1'b1, 1'b1, 1'b1);
    hold(1'b1, BIT_CLK);
    hold(1'b1, 100);
    scen_end("7e_ok", 6, 1, 8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 3 * BIT_CLK);
    scen_end("7e_err", 6, 2, 8'h7E, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
